// File: rtl/tff_pkg.sv
// tff_pkg
// Shared definitions for the TFF-mapped counter family.
//   MAX_WIDTH    : widest counter the family supports
//   tff_pol_e    : active clock edge of a cell (falling / rising)
//   tff_mode_e   : behaviour at the range ends (wrap / saturate)
//   tff_terminal : top-of-range value (MODULUS-1) as a MAX_WIDTH vector,
//                  computed in 64 bits so MODULUS = 2**32 does not overflow
package tff_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic {
        TFF_NEG = 1'b0,
        TFF_POS = 1'b1
    } tff_pol_e;

    typedef enum logic {
        TFF_WRAP = 1'b0,
        TFF_SAT  = 1'b1
    } tff_mode_e;

    function automatic logic [MAX_WIDTH-1:0] tff_terminal(input longint modulus);
        return MAX_WIDTH'(modulus - 64'sd1);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// tff_cell
// Single toggle flip-flop bit with synchronous clear and set.
//   C : clock, active edge chosen by CLK_POL
//   R : synchronous clear (Q <= 0)
//   S : synchronous set   (Q <= 1)
//   T : toggle enable     (Q <= Q ^ T)
//   Q : stored bit
// R and S take precedence over T; the parent never asserts R and S together.
module tff_cell
    import tff_pkg::*;
#(
    parameter tff_pol_e CLK_POL = TFF_POS
) (
    input  logic C,
    input  logic R,
    input  logic S,
    input  logic T,
    output logic Q
);

    generate
        if (CLK_POL == TFF_POS) begin : g_pos
            // Rising-edge storage: clear, then set, then toggle
            always_ff @(posedge C) begin
                if (R) begin
                    Q <= 1'b0;
                end else if (S) begin
                    Q <= 1'b1;
                end else begin
                    Q <= Q ^ T;
                end
            end
        end else begin : g_neg
            // Falling-edge storage: same priority as the rising-edge variant
            always_ff @(negedge C) begin
                if (R) begin
                    Q <= 1'b0;
                end else if (S) begin
                    Q <= 1'b1;
                end else begin
                    Q <= Q ^ T;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tff_counter.sv
// tff_counter
// Up/down counter built from a bank of WIDTH tff_cell bits.
//   C   : clock (rising edge when CLK_POL=1, falling edge when CLK_POL=0)
//   R   : synchronous active-high reset, Q <= RESET_VAL
//   E   : count enable
//   UP  : 1 = increment, 0 = decrement
//   LD  : parallel load of D (clamped to MODULUS-1)
//   D   : load value
//   Q   : counter value, range 0..MODULUS-1
//   TC  : terminal count, combinational from Q and UP
//   OVF : one-cycle pulse after a count that hit a range end
// Edge priority is R > LD > E. Reset and load drive the cells' set/clear
// inputs; counting drives only the toggle inputs.
module tff_counter
    import tff_pkg::*;
#(
    parameter int     WIDTH     = 8,
    parameter longint MODULUS   = longint'(1) << WIDTH,
    parameter int     SATURATE  = 0,
    parameter longint RESET_VAL = 0,
    parameter int     CLK_POL   = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    localparam tff_pol_e         POL   = (CLK_POL != 0) ? TFF_POS : TFF_NEG;
    localparam tff_mode_e        MODE  = (SATURATE != 0) ? TFF_SAT : TFF_WRAP;
    localparam logic [WIDTH-1:0] TERM  = WIDTH'(tff_terminal(MODULUS));
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam bit               POW2  = (MODULUS == (longint'(1) << WIDTH));

    // Parameter sanity: refuse to elaborate an impossible counter
    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("tff_counter: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("tff_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
            $error("tff_counter: RESET_VAL must be below MODULUS");
        end
    endgenerate

    logic             at_top;
    logic             at_bot;
    logic             count_en;
    logic             hit_end;
    logic             ovf_next;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] tv_cnt;
    logic [WIDTH-1:0] tv;
    logic [WIDTH-1:0] cell_set;
    logic [WIDTH-1:0] cell_clr;

    assign at_top   = (Q == TERM);
    assign at_bot   = (Q == '0);
    assign count_en = ~R & ~LD & E;
    assign hit_end  = UP ? at_top : at_bot;
    assign TC       = hit_end;
    assign ovf_next = count_en & hit_end;

    // Out-of-range load values clamp to the top of the range
    assign ld_val = (D > TERM) ? TERM : D;

    generate
        if (POW2 && MODE == TFF_WRAP) begin : g_ripple
            // Full binary range wrapping: bit i toggles when all lower bits
            // are ones (up) or zeros (down), which also covers the wrap
            always_comb begin
                logic chain;
                chain  = 1'b1;
                tv_cnt = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    tv_cnt[i] = chain;
                    chain     = chain & (UP ? Q[i] : ~Q[i]);
                end
            end
        end else begin : g_compare
            logic [WIDTH-1:0] q_next;

            // Arbitrary modulus or saturation: form the next value explicitly
            // and toggle exactly the bits that differ
            always_comb begin
                q_next = Q;
                if (UP) begin
                    if (at_top) begin
                        q_next = (MODE == TFF_SAT) ? Q : '0;
                    end else begin
                        q_next = Q + WIDTH'(1);
                    end
                end else begin
                    if (at_bot) begin
                        q_next = (MODE == TFF_SAT) ? Q : TERM;
                    end else begin
                        q_next = Q - WIDTH'(1);
                    end
                end
                tv_cnt = Q ^ q_next;
            end
        end
    endgenerate

    assign tv = count_en ? tv_cnt : '0;

    // Reset and load are applied through set/clear so they never depend on
    // the current count; exactly one of set/clear is active per bit
    assign cell_set = R ? RST_Q  : (LD ? ld_val  : '0);
    assign cell_clr = R ? ~RST_Q : (LD ? ~ld_val : '0);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            tff_cell #(
                .CLK_POL(POL)
            ) u_cell (
                .C(C),
                .R(cell_clr[i]),
                .S(cell_set[i]),
                .T(tv[i]),
                .Q(Q[i])
            );
        end
    endgenerate

    generate
        if (POL == TFF_POS) begin : g_ovf_pos
            // Range-end event, registered on the same edge as the count bits
            always_ff @(posedge C) begin
                if (R) begin
                    OVF <= 1'b0;
                end else begin
                    OVF <= ovf_next;
                end
            end
        end else begin : g_ovf_neg
            // Falling-edge variant of the range-end event register
            always_ff @(negedge C) begin
                if (R) begin
                    OVF <= 1'b0;
                end else begin
                    OVF <= ovf_next;
                end
            end
        end
    endgenerate

endmodule
